// File: rtl/neuron_lut_scheduler.sv
// Time-multiplexed LogicNets sparse-layer evaluator: one shared truth-table store,
// one neuron evaluated per cycle over a captured input vector.
module neuron_lut_scheduler #(
    parameter int IN_BITS     = 64,
    parameter int FAN_IN      = 8,
    parameter int NUM_NEURONS = 16,
    parameter int STRIDE      = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cfg_we,
    input  logic [$clog2(NUM_NEURONS)-1:0] cfg_neuron,
    input  logic [FAN_IN-1:0]              cfg_addr,
    input  logic                           cfg_data,
    output logic                           cfg_err,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [IN_BITS-1:0]             in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_NEURONS-1:0]         out_data,
    output logic                           busy
);
    localparam int NW    = $clog2(NUM_NEURONS);
    localparam int DEPTH = NUM_NEURONS << FAN_IN;
    localparam logic [NW-1:0] LAST = NW'(NUM_NEURONS - 1);
    localparam logic [NW:0]   NN   = (NW + 1)'(NUM_NEURONS);

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [IN_BITS-1:0]     r_in_q;
    logic [NW-1:0]          r_n;
    logic [NUM_NEURONS-1:0] r_out_data;
    logic                   r_out_valid;
    logic                   r_cfg_err;
    logic                   r_table [0:DEPTH-1];
    logic [FAN_IN-1:0]      w_addr_all [NUM_NEURONS];
    logic [FAN_IN-1:0]      w_addr;
    logic                   w_lut_bit;
    logic                   w_cfg_wr;

    // Per-neuron wiring uses elaboration-time wrapped indices, so no runtime modulo.
    for (genvar gn = 0; gn < NUM_NEURONS; gn++) begin : g_neuron
        for (genvar gk = 0; gk < FAN_IN; gk++) begin : g_tap
            localparam int IDX = (gn * STRIDE + gk) % IN_BITS;
            assign w_addr_all[gn][gk] = r_in_q[IDX];
        end
    end

    always_comb begin
        w_addr    = w_addr_all[r_n];
        w_lut_bit = r_table[{r_n, w_addr}];
        w_cfg_wr  = cfg_we && (r_state == S_IDLE) && ({1'b0, cfg_neuron} < NN);
    end

    always_ff @(posedge clk) begin
        if (w_cfg_wr)
            r_table[{cfg_neuron, cfg_addr}] <= cfg_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        busy        = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) w_state_nxt = S_EVAL;
            end
            S_EVAL:  if (r_n == LAST) w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_q      <= '0;
            r_n         <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_cfg_err <= cfg_we && !w_cfg_wr;
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_in_q <= in_data;
                        r_n    <= '0;
                    end
                end
                S_EVAL: begin
                    r_out_data[r_n] <= w_lut_bit;
                    if (r_n == LAST) begin
                        r_n         <= '0;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_n <= r_n + 1'b1;
                    end
                end
                S_DONE:  if (out_ready) r_out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign cfg_err   = r_cfg_err;
endmodule

// File: tb/tb_neuron_lut_scheduler.sv
// Directed self-checking bench for neuron_lut_scheduler with hand-computed expectations.
module tb_neuron_lut_scheduler;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_neuron = '0;
    logic [7:0]  cfg_addr = '0;
    logic        cfg_data = 1'b0;
    logic        cfg_err;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        busy;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    localparam logic [63:0] ALL1 = '1;

    neuron_lut_scheduler #(
        .IN_BITS(64), .FAN_IN(8), .NUM_NEURONS(16), .STRIDE(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_neuron(cfg_neuron), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [3:0] n, input logic [7:0] a, input logic d);
        cfg_we = 1'b1; cfg_neuron = n; cfg_addr = a; cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic accept(input logic [63:0] d);
        in_valid = 1'b1; in_data = d;
        tick();
        in_valid = 1'b0;
    endtask

    // Waits for out_valid; 'elapsed' is cycles already spent since the accepting edge.
    task automatic wait_done(input string tag, input int elapsed, input logic [15:0] exp);
        int cnt = elapsed;
        while (!out_valid && cnt < 40) begin
            tick();
            cnt++;
        end
        check({tag, "_latency"}, 64'(cnt), 64'd16);
        check({tag, "_data"}, 64'(out_data), 64'(exp));
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int unsigned bp_bad;

        // Reset values
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_cfg_err", 64'(cfg_err), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int unsigned n = 0; n < 16; n++)
            for (int unsigned a = 0; a < 256; a++)
                cfg_write(4'(n), 8'(a), 1'b0);
        check("idle_write_no_err", 64'(cfg_err), 64'd0);

        // Test 1: neuron0 fires only on 0xFF
        cfg_write(4'd0, 8'hFF, 1'b1);
        accept(ALL1);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_in_ready", 64'(in_ready), 64'd0);
        wait_done("t1", 0, 16'h0001);
        release_out();
        check("t1_released", 64'(out_valid), 64'd0);

        // Test 2 + 3: wrap-around neuron15, then backpressure in DONE
        cfg_write(4'd15, 8'h0F, 1'b1);
        accept(64'hF000_0000_0000_0000);
        wait_done("t2", 0, 16'h8000);
        bp_bad = 0;
        in_valid = 1'b1;
        in_data  = ALL1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid !== 1'b1 || out_data !== 16'h8000 || busy !== 1'b1 || in_ready !== 1'b0)
                bp_bad++;
        end
        check("t3_stable", 64'(bp_bad), 64'd0);
        release_out();
        in_valid = 1'b0;
        check("t3_xfer_valid", 64'(out_valid), 64'd0);
        check("t3_no_accept", 64'(busy), 64'd0);
        tick();
        check("t3_single", 64'(out_valid), 64'd0);
        check("t3_idle_ready", 64'(in_ready), 64'd1);

        // Test 4: config write during EVAL is rejected
        accept(ALL1);
        repeat (3) tick();
        cfg_write(4'd0, 8'hFF, 1'b0);
        check("t4_err_pulse", 64'(cfg_err), 64'd1);
        tick();
        check("t4_err_clear", 64'(cfg_err), 64'd0);
        wait_done("t4", 5, 16'h0001);
        release_out();

        // Test 5: same-cycle write alongside accept is visible
        cfg_we = 1'b1; cfg_neuron = 4'd0; cfg_addr = 8'hFF; cfg_data = 1'b0;
        accept(ALL1);
        cfg_we = 1'b0;
        check("t5_no_err", 64'(cfg_err), 64'd0);
        wait_done("t5", 0, 16'h0000);
        release_out();
        cfg_write(4'd0, 8'hFF, 1'b1);

        // Test 6: async reset mid-EVAL, table survives
        accept(ALL1);
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        check("t6_out_valid", 64'(out_valid), 64'd0);
        check("t6_out_data", 64'(out_data), 64'd0);
        check("t6_in_ready", 64'(in_ready), 64'd1);
        #3;
        rst_n = 1'b1;
        tick();
        accept(ALL1);
        wait_done("t6", 0, 16'h0001);
        release_out();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
